// File: rtl/param_counter_pkg.sv
// Shared encodings for the parameterised up/down counter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a; the counter has no flow control.
//
// Contents:
//   mode_e    overflow mode encoding as seen on the 2-bit mode input
//   state_e   two-state FSM encoding (RUN, STOP)
//   norm_mode folds the spare mode code onto WRAP
package param_counter_pkg;

  // Overflow behaviour at the terminal value. The fourth code is not a
  // separate behaviour; it is folded onto WRAP by norm_mode().
  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  // STOP is only ever entered from ONESHOT mode.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_e;

  // Map the raw mode pins onto the three real behaviours so that the
  // next-value logic never has to special-case the spare code.
  function automatic mode_e norm_mode(input logic [1:0] i_mode);
    mode_e r_m;
    case (i_mode)
      2'b01:   r_m = MODE_SAT;
      2'b10:   r_m = MODE_ONESHOT;
      default: r_m = MODE_WRAP;
    endcase
    return r_m;
  endfunction

endpackage

// File: rtl/param_counter_next.sv
// Combinational next-value, terminal and overflow-event logic for param_counter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs are only consumed on a count event or a load.
//
// Ports:
//   i_value        current registered count (always <= MAX)
//   i_up           direction, 1 = up, 0 = down
//   i_mode         normalised overflow mode (WRAP, SAT, ONESHOT)
//   i_load_value   raw load value
//   o_count_value  value the register takes if a count event happens
//   o_wrap_evt     a count event now would be a WRAP rollover
//   o_ovf_evt      a count event now would attempt to pass the terminal
//   o_stop_evt     a count event now would move the FSM into STOP
//   o_load_value   load value clipped to MAX
module param_counter_next
  import param_counter_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_up,
  input  mode_e            i_mode,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_count_value,
  output logic             o_wrap_evt,
  output logic             o_ovf_evt,
  output logic             o_stop_evt,
  output logic [WIDTH-1:0] o_load_value
);

  logic [WIDTH-1:0] w_terminal;
  logic [WIDTH-1:0] w_step;
  logic             w_at_term;

  // The terminal follows the direction pin every cycle, so a direction
  // change simply retargets the next count event.
  assign w_terminal = i_up ? MAX : '0;
  assign w_at_term  = (i_value == w_terminal);

  // Only used when not at the terminal, so it can never leave 0..MAX.
  assign w_step = i_up ? (i_value + 1'b1) : (i_value - 1'b1);

  // Loads above MAX saturate so the register never leaves 0..MAX.
  assign o_load_value = (i_load_value > MAX) ? MAX : i_load_value;

  always_comb begin
    o_count_value = i_value;
    o_wrap_evt    = 1'b0;
    o_ovf_evt     = 1'b0;
    o_stop_evt    = 1'b0;

    if (!w_at_term) begin
      o_count_value = w_step;
      // ONESHOT stops on the edge that lands on the terminal, not the
      // one after it, so no overflow is flagged for a clean arrival.
      o_stop_evt    = (i_mode == MODE_ONESHOT) && (w_step == w_terminal);
    end else begin
      o_ovf_evt = 1'b1;
      case (i_mode)
        MODE_SAT: begin
          o_count_value = i_value;
        end
        MODE_ONESHOT: begin
          o_count_value = i_value;
          o_stop_evt    = 1'b1;
        end
        default: begin
          // WRAP: roll to the opposite end of the range.
          o_count_value = i_up ? '0 : MAX;
          o_wrap_evt    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/param_counter.sv
// Parameterised up/down counter with WRAP / SAT / ONESHOT overflow modes.
// Latency: one clock from clear/load/count to value, wrap, ovf and done.
// Backpressure: none; en gates counting and is ignored while done is high.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset (value=INIT, flags 0, RUN)
//   clear       synchronous clear to INIT, highest synchronous priority
//   load        synchronous load of min(load_value, MAX)
//   load_value  value to load
//   en          count enable (only honoured in RUN)
//   up          direction: 1 up towards MAX, 0 down towards 0
//   mode        00 WRAP, 01 SAT, 10 ONESHOT, 11 WRAP
//   value       registered count, always within 0..MAX
//   wrap        one-cycle pulse following each WRAP rollover
//   ovf         sticky: a count was attempted past the terminal
//   done        high while the FSM sits in STOP
//
// Parameter legality (WIDTH 2..32, MAX < 2**WIDTH, INIT <= MAX) is the
// instantiator's responsibility; MAX's width enforces the middle one.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  // All-ones, i.e. 2**WIDTH-1, written so it stays valid at WIDTH=32.
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] value,
  output logic             wrap,
  output logic             ovf,
  output logic             done
);

  state_e           r_state;
  logic [WIDTH-1:0] r_value;
  logic             r_wrap;
  logic             r_ovf;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_value_nxt;
  logic             w_wrap_nxt;
  logic             w_ovf_nxt;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_count_value;
  logic [WIDTH-1:0] w_load_clip;
  logic             w_wrap_evt;
  logic             w_ovf_evt;
  logic             w_stop_evt;

  assign w_mode = norm_mode(mode);

  param_counter_next #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_next (
    .i_value       (r_value),
    .i_up          (up),
    .i_mode        (w_mode),
    .i_load_value  (load_value),
    .o_count_value (w_count_value),
    .o_wrap_evt    (w_wrap_evt),
    .o_ovf_evt     (w_ovf_evt),
    .o_stop_evt    (w_stop_evt),
    .o_load_value  (w_load_clip)
  );

  // Next-state and next-datapath decode. clear beats load beats count,
  // so at most one action lands on any edge. wrap defaults low so it can
  // only ever be a single-cycle pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_value_nxt = r_value;
    w_wrap_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;

    if (clear) begin
      w_value_nxt = INIT;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = ST_RUN;
    end else if (load) begin
      w_value_nxt = w_load_clip;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (en) begin
            w_value_nxt = w_count_value;
            w_wrap_nxt  = w_wrap_evt;
            w_ovf_nxt   = r_ovf | w_ovf_evt;
            if (w_stop_evt) begin
              w_state_nxt = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          // Parked: en, up and mode are all ignored until clear or load.
          w_state_nxt = ST_STOP;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Reset wins over everything in flight, including a same-cycle clear,
  // load or count, and takes effect without waiting for an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_value <= INIT;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_value <= w_value_nxt;
      r_wrap  <= w_wrap_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign value = r_value;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;
  assign done  = (r_state == ST_STOP);

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: table-driven vectors through a
// scoreboard queue, plus hand sequences for async reset and a width sweep.
// Main DUT: WIDTH=8 MAX=9 INIT=0; sweep DUTs: 4/15/0 and 16/1000/5.
module tb_param_counter;
  import param_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        load;
  logic [7:0]  load_value;
  logic        en;
  logic        up;
  logic [1:0]  mode;

  logic [7:0]  value;
  logic        wrap, ovf, done;
  logic [3:0]  value4;
  logic        wrap4, ovf4, done4;
  logic [15:0] value16;
  logic        wrap16, ovf16, done16;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(8), .MAX(8'd9), .INIT(8'd0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_value(load_value), .en(en), .up(up), .mode(mode),
    .value(value), .wrap(wrap), .ovf(ovf), .done(done)
  );

  param_counter #(.WIDTH(4), .MAX(4'd15), .INIT(4'd0)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_value(load_value[3:0]), .en(en), .up(up), .mode(mode),
    .value(value4), .wrap(wrap4), .ovf(ovf4), .done(done4)
  );

  param_counter #(.WIDTH(16), .MAX(16'd1000), .INIT(16'd5)) dut16 (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_value({8'h00, load_value}), .en(en), .up(up), .mode(mode),
    .value(value16), .wrap(wrap16), .ovf(ovf16), .done(done16)
  );

  typedef struct packed {
    logic       clr;
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic [1:0] md;
    logic [7:0] v;
    logic       w;
    logic       o;
    logic       d;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int clr_i, input int ld_i, input int lv_i,
                              input int en_i, input int up_i, input int md_i,
                              input int v_i, input int w_i, input int o_i,
                              input int d_i);
    vec_t r;
    r.clr = (clr_i != 0);
    r.ld  = (ld_i != 0);
    r.lv  = 8'(lv_i);
    r.en  = (en_i != 0);
    r.up  = (up_i != 0);
    r.md  = 2'(md_i);
    r.v   = 8'(v_i);
    r.w   = (w_i != 0);
    r.o   = (o_i != 0);
    r.d   = (d_i != 0);
    return r;
  endfunction

  // Pop the oldest expectation and compare it with the main DUT.
  task automatic check_out(input string tag, input int idx);
    vec_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s[%0d]: scoreboard empty when output sampled", tag, idx);
      return;
    end
    e = sb_q.pop_front();
    if ({value, wrap, ovf, done} !== {e.v, e.w, e.o, e.d}) begin
      n_err++;
      $display("FAIL %s[%0d]: got value=%0d wrap=%0b ovf=%0b done=%0b, want value=%0d wrap=%0b ovf=%0b done=%0b",
               tag, idx, value, wrap, ovf, done, e.v, e.w, e.o, e.d);
    end
  endtask

  task automatic apply_vec(input vec_t t, input int idx);
    @(negedge clk);
    clear      = t.clr;
    load       = t.ld;
    load_value = t.lv;
    en         = t.en;
    up         = t.up;
    mode       = t.md;
    sb_q.push_back(t);
    @(posedge clk);
    #1;
    check_out("tbl", idx);
  endtask

  task automatic check_sweep(input string tag, input int idx,
                             input int got_v, input int got_w, input int got_o, input int got_d,
                             input int exp_v, input int exp_w, input int exp_o);
    n_vec++;
    if (got_v != exp_v || got_w != exp_w || got_o != exp_o || got_d != 0) begin
      n_err++;
      $display("FAIL %s[%0d]: got value=%0d wrap=%0d ovf=%0d done=%0d, want value=%0d wrap=%0d ovf=%0d done=0",
               tag, idx, got_v, got_w, got_o, got_d, exp_v, exp_w, exp_o);
    end
  endtask

  initial begin
    int e4, e16, o4, o16, w4e, w16e, nw4, nw16;

    // ---------------- vector table ----------------
    // WRAP up, 12 counts from reset.
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0,0,0, 1,1,MODE_WRAP, i,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,MODE_WRAP, 0,1,1,0));
    tbl.push_back(mk(0,0,0, 1,1,MODE_WRAP, 1,0,1,0));
    tbl.push_back(mk(0,0,0, 1,1,MODE_WRAP, 2,0,1,0));
    // SAT down from a load of 2.
    tbl.push_back(mk(0,1,2, 0,0,MODE_SAT, 2,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_SAT, 1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_SAT, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_SAT, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_SAT, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_SAT, 0,0,1,0));
    // Spare mode code behaves as WRAP (down through zero), then idle.
    tbl.push_back(mk(0,0,0, 1,0,3, 9,1,1,0));
    tbl.push_back(mk(0,0,0, 0,0,3, 9,0,1,0));
    // ONESHOT up from 7: stop on arrival at 9, ignore en/mode/up in STOP.
    tbl.push_back(mk(0,1,7, 0,1,MODE_ONESHOT, 7,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,MODE_ONESHOT, 8,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,MODE_ONESHOT, 9,0,0,1));
    tbl.push_back(mk(0,0,0, 1,1,MODE_ONESHOT, 9,0,0,1));
    tbl.push_back(mk(0,0,0, 1,1,MODE_ONESHOT, 9,0,0,1));
    tbl.push_back(mk(0,0,0, 1,1,MODE_ONESHOT, 9,0,0,1));
    tbl.push_back(mk(0,0,0, 1,1,MODE_WRAP,    9,0,0,1));
    tbl.push_back(mk(0,0,0, 1,0,MODE_SAT,     9,0,0,1));
    tbl.push_back(mk(0,1,3, 1,1,MODE_ONESHOT, 3,0,0,0));
    // ONESHOT count attempted at the terminal while in RUN.
    tbl.push_back(mk(0,1,9, 0,1,MODE_ONESHOT, 9,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,MODE_ONESHOT, 9,0,1,1));
    tbl.push_back(mk(1,0,0, 1,1,MODE_ONESHOT, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_ONESHOT, 0,0,1,1));
    tbl.push_back(mk(0,1,1, 0,0,MODE_ONESHOT, 1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_ONESHOT, 0,0,0,1));
    // Priority and load clipping.
    tbl.push_back(mk(0,1,5,   0,1,MODE_WRAP, 5,0,0,0));
    tbl.push_back(mk(1,1,77,  1,1,MODE_WRAP, 0,0,0,0));
    tbl.push_back(mk(0,1,200, 0,1,MODE_WRAP, 9,0,0,0));
    tbl.push_back(mk(0,0,0,   1,1,MODE_WRAP, 0,1,1,0));
    tbl.push_back(mk(0,1,250, 0,1,MODE_WRAP, 9,0,0,0));
    // Direction and mode changes between counts.
    tbl.push_back(mk(0,0,0, 1,0,MODE_WRAP, 8,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,MODE_WRAP, 9,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,MODE_SAT,  9,0,1,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_WRAP, 8,0,1,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_WRAP, 7,0,1,0));
    tbl.push_back(mk(0,0,0, 1,0,MODE_WRAP, 6,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,MODE_WRAP, 6,0,1,0));

    // ---------------- reset state ----------------
    reset = 1'b0; clear = 1'b0; load = 1'b0; load_value = 8'd0;
    en = 1'b0; up = 1'b0; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(mk(0,0,0, 0,0,0, 0,0,0,0));
    check_out("reset", 0);
    check_sweep("reset16", 0, int'(value16), int'(wrap16), int'(ovf16), int'(done16), 5, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

    // ---------------- async reset mid-cycle ----------------
    // Main DUT now sits at value 6 with ovf set; assert reset between edges.
    #1;
    en = 1'b1; up = 1'b1; mode = MODE_WRAP; clear = 1'b0; load = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    sb_q.push_back(mk(0,0,0, 0,0,0, 0,0,0,0));
    check_out("arst_now", 0);
    @(posedge clk);
    #1;
    sb_q.push_back(mk(0,0,0, 0,0,0, 0,0,0,0));
    check_out("arst_hold", 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      sb_q.push_back(mk(0,0,0, 1,1,MODE_WRAP, i,0,0,0));
      @(posedge clk);
      #1;
      check_out("arst_resume", i);
    end

    // ---------------- width sweep: down through zero in WRAP ----------------
    @(negedge clk);
    load = 1'b1; load_value = 8'd2; en = 1'b0;
    @(posedge clk);
    #1;
    check_sweep("sw4_load",  0, int'(value4),  int'(wrap4),  int'(ovf4),  int'(done4),  2, 0, 0);
    check_sweep("sw16_load", 0, int'(value16), int'(wrap16), int'(ovf16), int'(done16), 2, 0, 0);
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b0; mode = MODE_WRAP;
    e4 = 2; e16 = 2; o4 = 0; o16 = 0; nw4 = 0; nw16 = 0;
    for (int i = 0; i < 6; i++) begin
      w4e  = (e4 == 0)  ? 1 : 0;
      w16e = (e16 == 0) ? 1 : 0;
      e4   = (e4 == 0)  ? 15   : e4 - 1;
      e16  = (e16 == 0) ? 1000 : e16 - 1;
      if (w4e != 0)  o4 = 1;
      if (w16e != 0) o16 = 1;
      @(posedge clk);
      #1;
      if (wrap4)  nw4++;
      if (wrap16) nw16++;
      check_sweep("sw4",  i, int'(value4),  int'(wrap4),  int'(ovf4),  int'(done4),  e4,  w4e,  o4);
      check_sweep("sw16", i, int'(value16), int'(wrap16), int'(ovf16), int'(done16), e16, w16e, o16);
    end
    n_vec++;
    if (nw4 != 1) begin
      n_err++;
      $display("FAIL sw4_wrap_count: got %0d pulses, want 1", nw4);
    end
    n_vec++;
    if (nw16 != 1) begin
      n_err++;
      $display("FAIL sw16_wrap_count: got %0d pulses, want 1", nw16);
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d leftover entries, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
